multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 91 +++++++++
 tb/tb_multiplier.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// Sequential shift-add unsigned multiplier: one partial-product step per clock,
// fixed WIDTH-cycle latency, registered product and done handshake held until start drops.
module multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [2*WIDTH:0]     acc_r;
  logic [2*WIDTH:0]     acc_next_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH:0]       upper_s;

  // One shift-add step: the low half of the accumulator still holds the unconsumed multiplier bits.
  always_comb begin
    upper_s = acc_r[2*WIDTH:WIDTH];
    if (acc_r[0]) begin
      upper_s = acc_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
    end else begin
      upper_s = acc_r[2*WIDTH:WIDTH];
    end
    acc_next_s = {upper_s, acc_r[WIDTH-1:0]} >> 1;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      product <= '0;
      done    <= 1'b0;
      acc_r   <= '0;
      mcand_r <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r <= data1;
            acc_r   <= {{(WIDTH+1){1'b0}}, data2};
            cnt_r   <= '0;
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CW'(1);
          // The final step's result goes straight to product so latency stays at WIDTH edges.
          if (cnt_r == LAST_ITER) begin
            product <= acc_next_s[2*WIDTH-1:0];
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (!start) begin
            done    <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: vector table driven through a scoreboard queue, plus reset
// and operand-change sequences.
module tb_multiplier;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic [15:0] product;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    bit          chg;
  } vec_t;

  vec_t vecs[8];

  multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .data1   (data1),
    .data2   (data2),
    .product (product),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit chg);
    int   k;
    bit   found;
    logic [15:0] want;
    found = 1'b0;
    k = 0;
    @(negedge clk);
    data1 = a;
    data2 = b;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check1("done_low_at_capture", done, 1'b0);
    if (chg) begin
      data1 = 8'h00;
      data2 = 8'h00;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        found = 1'b1;
        k = i;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=8");
    end else begin
      checks++;
      if (k != 8) begin
        errors++;
        $display("FAIL latency actual=%0d required=8", k);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=%h required=entry", product);
      end else begin
        want = exp_q.pop_front();
        check16("product", product, want);
      end
      for (int j = 0; j < 2; j++) begin
        @(posedge clk);
        #1;
        check1("done_held", done, 1'b1);
        check16("product_held", product, exp);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check1("done_falls", done, 1'b0);
      check16("product_retained", product, exp);
    end
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    bit          saw_done;
    logic [7:0]  rst_a[3];
    logic [7:0]  rst_b[3];

    vecs[0] = '{8'hCC, 8'h8E, 16'h7128, 1'b0};
    vecs[1] = '{8'h1A, 8'h2D, 16'h0492, 1'b0};
    vecs[2] = '{8'h64, 8'hB3, 16'h45EC, 1'b0};
    vecs[3] = '{8'hC7, 8'h39, 16'h2C4F, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[5] = '{8'h00, 8'hA5, 16'h0000, 1'b0};
    vecs[6] = '{8'h01, 8'h80, 16'h0080, 1'b0};
    vecs[7] = '{8'hC7, 8'h39, 16'h2C4F, 1'b1};
    rst_a[0] = 8'h1A; rst_b[0] = 8'h2D;
    rst_a[1] = 8'h64; rst_b[1] = 8'hB3;
    rst_a[2] = 8'hC7; rst_b[2] = 8'h39;

    reset_n = 1'b0;
    start   = 1'b0;
    data1   = 8'h00;
    data2   = 8'h00;
    #1;
    check16("reset_product", product, 16'h0000);
    check1("reset_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data1 = rst_a[i];
      data2 = rst_b[i];
      @(posedge clk);
      #1;
      check16("reset_hold_product", product, 16'h0000);
      check1("reset_hold_done", done, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check1("idle_no_start_done", done, 1'b0);
      check16("idle_no_start_product", product, 16'h0000);
    end

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].chg);
    end

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 16'(ra) * 16'(rb), 1'b0);
    end

    // Abort mid-calculation: product currently holds a nonzero prior result.
    run_op(8'hC7, 8'h39, 16'h2C4F, 1'b0);
    @(negedge clk);
    data1 = 8'hC7;
    data2 = 8'h39;
    start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check16("midcalc_reset_product", product, 16'h0000);
    check1("midcalc_reset_done", done, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    check1("no_done_after_abort", saw_done, 1'b0);
    check16("product_after_abort", product, 16'h0000);
    run_op(8'h3C, 8'h5A, 16'h1518, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
